// File: rtl/fp_alu_arbiter.sv
// rtl/fp_alu_arbiter.sv - round-robin arbiter sharing one fixed-point ALU among N_REQ requesters
// Optional stats counters: define FP_ALU_ARB_STATS_EN.
module fp_alu_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = $clog2(N_REQ),
    parameter int ALU_LATENCY = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 enable_in,
    input  logic [N_REQ-1:0]     req_valid_in,
    output logic [N_REQ-1:0]     req_ready_out,
    input  logic [32*N_REQ-1:0]  req_d0_in,
    input  logic [32*N_REQ-1:0]  req_d1_in,
    input  logic [3*N_REQ-1:0]   req_sel_in,
    output logic [31:0]          alu_d0_out,
    output logic [31:0]          alu_d1_out,
    output logic [2:0]           alu_sel_out,
    input  logic [31:0]          alu_res_in,
    input  logic                 alu_gt_in,
    input  logic                 alu_eq_in,
    output logic                 resp_valid_out,
    output logic [ID_W-1:0]      resp_id_out,
    output logic [31:0]          resp_res_out,
    output logic                 resp_gt_out,
    output logic                 resp_eq_out
`ifdef FP_ALU_ARB_STATS_EN
    ,
    output logic [31:0]          stat_ops_out,
    output logic [31:0]          stat_stall_out
`endif
);

    logic [ID_W-1:0]                  ptr;
    logic [N_REQ-1:0]                 grant;
    logic [ID_W-1:0]                  gnt_id;
    logic                             hs;
    logic [ID_W:0]                    sum;
    logic [ID_W-1:0]                  idx;
    logic [ALU_LATENCY:0]             tag_v;
    logic [ALU_LATENCY:0][ID_W-1:0]   tag_id;

    // First valid requester at or after the pointer wins; reset and enable gate the grant.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        hs     = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + k[ID_W:0];
            if (sum >= (ID_W+1)'(N_REQ))
                sum = sum - (ID_W+1)'(N_REQ);
            idx = sum[ID_W-1:0];
            if (!hs && req_valid_in[idx]) begin
                hs          = 1'b1;
                grant[idx]  = 1'b1;
                gnt_id      = idx;
            end
        end
        if (!enable_in || !rst_n_in) begin
            grant = '0;
            hs    = 1'b0;
        end
    end

    assign req_ready_out = grant;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr            <= '0;
            alu_d0_out     <= '0;
            alu_d1_out     <= '0;
            alu_sel_out    <= '0;
            tag_v          <= '0;
            tag_id         <= '0;
            resp_valid_out <= 1'b0;
            resp_id_out    <= '0;
            resp_res_out   <= '0;
            resp_gt_out    <= 1'b0;
            resp_eq_out    <= 1'b0;
        end else begin
            tag_v[0]  <= hs;
            tag_id[0] <= gnt_id;
            for (int i = 1; i <= ALU_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (hs) begin
                ptr         <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
                alu_d0_out  <= req_d0_in[int'(gnt_id)*32 +: 32];
                alu_d1_out  <= req_d1_in[int'(gnt_id)*32 +: 32];
                alu_sel_out <= req_sel_in[int'(gnt_id)*3 +: 3];
            end
            // The last tag stage lines up with the cycle the ALU result is valid.
            resp_valid_out <= tag_v[ALU_LATENCY];
            if (tag_v[ALU_LATENCY]) begin
                resp_id_out  <= tag_id[ALU_LATENCY];
                resp_res_out <= alu_res_in;
                resp_gt_out  <= alu_gt_in;
                resp_eq_out  <= alu_eq_in;
            end
        end
    end

`ifdef FP_ALU_ARB_STATS_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat_ops_out   <= '0;
            stat_stall_out <= '0;
        end else begin
            if (hs && stat_ops_out != 32'hFFFF_FFFF)
                stat_ops_out <= stat_ops_out + 32'd1;
            if (|req_valid_in && !hs && stat_stall_out != 32'hFFFF_FFFF)
                stat_stall_out <= stat_stall_out + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fp_alu_arbiter.md
Name: fp_alu_arbiter

Overview:
- Shares one fixed_point_alu instance among N_REQ requesters, e.g. ray-marcher stages that need occasional Q12.20 ops.
- Round-robin grant with valid/ready on the request side and at most one issue per cycle.
- Returns result, gt and eq to the granted requester, tagged with its ID, after a fixed pipeline latency.
- Sits between requester FSMs and the ALU; drives the ALU's d0/d1/sel inputs and samples res/gt/eq.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), requester ID width.
- ALU_LATENCY, 0, cycles from ALU operands registered to alu_res_in valid (0 = combinational ALU).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- enable_in  input  1  when low no new grants; in-flight ops drain.
- req_valid_in  input  N_REQ  per-requester request valid.
- req_ready_out  output  N_REQ  one-hot grant; handshake when valid&ready.
- req_d0_in  input  32*N_REQ  packed Q12.20 operand 0, requester i at [32i+31:32i].
- req_d1_in  input  32*N_REQ  packed Q12.20 operand 1.
- req_sel_in  input  3*N_REQ  packed ALU op select, passed through unmodified.
- alu_d0_out  output  32  ALU operand 0 (registered).
- alu_d1_out  output  32  ALU operand 1 (registered).
- alu_sel_out  output  3  ALU op select (registered).
- alu_res_in  input  32  ALU result.
- alu_gt_in  input  1  ALU greater-than flag.
- alu_eq_in  input  1  ALU equal flag.
- resp_valid_out  output  1  response valid, one-cycle pulse per op.
- resp_id_out  output  ID_W  requester the response belongs to.
- resp_res_out  output  32  captured result.
- resp_gt_out  output  1  captured gt.
- resp_eq_out  output  1  captured eq.

Behaviour:
- Reset (rst_n_in low, async): rr pointer=0, all alu_*_out=0, all resp_*_out=0, tag pipeline cleared. Ops in flight are dropped and produce no response. req_ready_out=0 while in reset.
- Grant: combinational from req_valid_in, rr pointer and enable_in. The first valid requester searching from pointer upward (wrapping at N_REQ-1→0) gets req_ready_out[i]=1; at most one bit is set. enable_in=0 forces req_ready_out=0.
- Pointer update: on a handshake with requester i, pointer ← (i+1) mod N_REQ. With no handshake the pointer holds.
- Issue (handshake at cycle T): at T+1, alu_d0/d1/sel_out hold requester i's operands and tag {valid=1, id=i} enters the tag pipeline. Without a handshake, alu_*_out hold their previous values and the tag valid is 0.
- Tag pipeline depth is ALU_LATENCY+1. The ALU result is sampled at the edge ending cycle T+1+ALU_LATENCY.
- Response: resp_valid_out=1 for exactly cycle T+2+ALU_LATENCY with the matching id/res/gt/eq. resp_res/gt/eq/id hold their last value when resp_valid_out=0.
- Fixed latency from handshake to response is ALU_LATENCY+2. No response backpressure: requesters must accept the pulse.
- Throughput: one issue per cycle sustained, in-order responses. Back-to-back grants are allowed, including to the same requester when it is the only one valid.
- Operand fairness: no requester waits more than N_REQ-1 handshakes of others while continuously valid.
- Dropping enable_in mid-stream does not cancel issued ops; their responses still emerge.

Optional Feature:
- Macro FP_ALU_ARB_STATS_EN.
- When defined, adds output stat_ops_out (32) and stat_stall_out (32), both reset to 0.
  - stat_ops_out counts handshakes.
  - stat_stall_out counts cycles where any req_valid_in is high but no handshake occurs (enable low or a requester not granted).
  - Both counters saturate at 0xFFFFFFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Bench ALU stub: res=d0+d1, gt=(d0>d1 signed), eq=(d0==d1), ALU_LATENCY=0.
- Single request: req0 d0=0x00100000, d1=0x00200000, sel=3'b010, valid at cycle 5 → ready[0]=1 at 5. alu_sel_out=3'b010 at 6. resp_valid=1 at 7 with id=0, res=0x00300000, gt=0, eq=0.
- All four requesters valid continuously from reset → grants 0,1,2,3,0,1 on consecutive cycles. Responses return ids in the same order, one per cycle.
- Pointer after grant to requester 2, then only req1 and req3 valid → req3 granted first, then req1.
- ALU_LATENCY=3, requester 1 with d0=d1=0x00080000 handshake at cycle 10 → resp_valid at cycle 15, id=1, res=0x00100000, eq=1, gt=0.
- Async reset asserted at cycle 11 with two ops in flight, released at 13 → no resp_valid pulses, all outputs 0, next grant goes to requester 0.
- enable_in=0 for cycles 20–24 with req0 valid → no ready during 20–24, grant at 25. With STATS_EN, stat_stall_out increments by 5.
